// File: rtl/vp_frame_writer.sv
// vp_frame_writer: turns a ready/valid pixel stream into raster writes for a
// double-buffered frame memory, flipping banks on every completed frame.
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_enable           allows capture to start/continue (a started frame always finishes)
//   i_sof              start-of-frame resync; aborts a partial frame
//   i_data_valid/i_data, o_data_ready   upstream pixel handshake
//   i_wr_stall         memory cannot accept a write this cycle
//   o_wr_en/o_wr_addr/o_wr_data         memory write port, one cycle after transfer
//   o_disp_bank        bank holding the last completed frame
//   o_frame_done/o_frame_err            one-cycle completion / abort pulses
//   o_frame_cnt        completed-frame count (wraps)
module vp_frame_writer #(
    parameter int DW   = 8,
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int AW   = 20
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_enable,
    input  logic          i_sof,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_wr_stall,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_disp_bank,
    output logic          o_frame_done,
    output logic          o_frame_err,
    output logic [15:0]   o_frame_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int CW    = $clog2(COLS > 1 ? COLS : 2);
    localparam int RW    = $clog2(ROWS > 1 ? ROWS : 2);
    localparam int FRAME = COLS * ROWS;
    state_t        state, state_nx;
    logic [CW-1:0] col, col_nx;
    logic [RW-1:0] row, row_nx;
    logic          wbank, wbank_nx;
    logic          wr_en_nx, disp_nx, done_nx, err_nx;
    logic [AW-1:0] wr_addr_nx;
    logic [DW-1:0] wr_data_nx;
    logic [15:0]   cnt_nx;
    logic          xfer, sof, last_col, last_row;
    assign o_data_ready = (state == RUN) && !i_wr_stall;
    assign xfer     = i_data_valid && o_data_ready;
    assign sof      = i_sof && (state == RUN);
    assign last_col = col == CW'(COLS - 1);
    assign last_row = row == RW'(ROWS - 1);
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_nx     = row;
        wbank_nx   = wbank;
        wr_en_nx   = xfer;
        wr_addr_nx = o_wr_addr;
        wr_data_nx = o_wr_data;
        disp_nx    = o_disp_bank;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        cnt_nx     = o_frame_cnt;
        if (xfer) begin
            // a resync pixel lands at offset 0 of the bank being written
            wr_addr_nx = (wbank ? AW'(FRAME) : {AW{1'b0}})
                       + (sof ? {AW{1'b0}} : AW'(row) * AW'(COLS) + AW'(col));
            wr_data_nx = i_data;
        end
        if (sof) begin
            err_nx = (col != '0) || (row != '0);
            col_nx = xfer ? CW'(1) : '0;
            row_nx = '0;
        end else if (xfer && last_col) begin
            col_nx = '0;
            if (last_row) begin
                row_nx   = '0;
                done_nx  = 1'b1;
                disp_nx  = wbank;
                wbank_nx = !wbank;
                cnt_nx   = o_frame_cnt + 16'd1;
                if (!i_enable) state_nx = IDLE;
            end else begin
                row_nx = row + RW'(1);
            end
        end else if (xfer) begin
            col_nx = col + CW'(1);
        end
        if (state == IDLE && i_enable) state_nx = RUN;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            wbank        <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_disp_bank  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_frame_cnt  <= '0;
        end else begin
            state        <= state_nx;
            col          <= col_nx;
            row          <= row_nx;
            wbank        <= wbank_nx;
            o_wr_en      <= wr_en_nx;
            o_wr_addr    <= wr_addr_nx;
            o_wr_data    <= wr_data_nx;
            o_disp_bank  <= disp_nx;
            o_frame_done <= done_nx;
            o_frame_err  <= err_nx;
            o_frame_cnt  <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_vp_frame_writer.sv
// tb_vp_frame_writer: directed scenarios plus random traffic against a
// pixel-index reference model of the frame writer (4x3 frame, 5-bit address).
module tb_vp_frame_writer;
    localparam int FR = 12;
    logic       i_clk = 1'b0;
    logic       i_rstn, i_enable, i_sof, i_data_valid, i_wr_stall;
    logic [7:0] i_data;
    logic       o_data_ready, o_wr_en, o_disp_bank, o_frame_done, o_frame_err;
    logic [4:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic [15:0] o_frame_cnt;
    int checks = 0;
    int errors = 0;
    bit known = 0;
    bit m_run, m_bank, m_disp, m_wr_en, m_done, m_err;
    int m_p, m_addr, m_data;
    logic [15:0] m_cnt;

    vp_frame_writer #(.DW(8), .COLS(4), .ROWS(3), .AW(5)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_sof(i_sof),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
        .i_wr_stall(i_wr_stall), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_disp_bank(o_disp_bank), .o_frame_done(o_frame_done),
        .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check ready, advance the model, check registered outputs.
    task automatic step(input bit rn, input bit en, input bit sf, input bit v, input bit st,
                        input logic [7:0] d);
        bit xfer;
        i_rstn = rn; i_enable = en; i_sof = sf; i_data_valid = v; i_wr_stall = st; i_data = d;
        #1;
        if (known) check("ready", {31'd0, o_data_ready}, {31'd0, m_run && !st});
        if (!rn) begin
            m_run = 0; m_bank = 0; m_disp = 0; m_wr_en = 0; m_done = 0; m_err = 0;
            m_p = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        end else begin
            xfer = v && m_run && !st;
            m_done = 0; m_err = 0; m_wr_en = xfer;
            if (xfer) begin
                m_addr = m_bank * FR + ((m_run && sf) ? 0 : m_p);
                m_data = d;
            end
            if (m_run && sf) begin
                m_err = m_p != 0;
                m_p = xfer ? 1 : 0;
            end else if (xfer) begin
                if (m_p == FR - 1) begin
                    m_p = 0; m_done = 1; m_disp = m_bank; m_bank = !m_bank; m_cnt = m_cnt + 16'd1;
                    if (!en) m_run = 0;
                end else begin
                    m_p++;
                end
            end else if (!m_run && en) begin
                m_run = 1;
            end
        end
        @(posedge i_clk);
        #1;
        known = 1;
        check("wr_en", {31'd0, o_wr_en}, {31'd0, m_wr_en});
        check("wr_addr", {27'd0, o_wr_addr}, m_addr);
        check("wr_data", {24'd0, o_wr_data}, m_data);
        check("frame_done", {31'd0, o_frame_done}, {31'd0, m_done});
        check("frame_err", {31'd0, o_frame_err}, {31'd0, m_err});
        check("disp_bank", {31'd0, o_disp_bank}, {31'd0, m_disp});
        check("frame_cnt", {16'd0, o_frame_cnt}, {16'd0, m_cnt});
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 8'h00);
        check("rst_cnt", {16'd0, o_frame_cnt}, 32'd0);
        step(1, 1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 12; i++) step(1, 1, 0, 1, 0, 8'(i));
        check("f1_done", {31'd0, o_frame_done}, 32'd1);
        check("f1_disp", {31'd0, o_disp_bank}, 32'd0);
        check("f1_cnt", {16'd0, o_frame_cnt}, 32'd1);
        check("f1_addr", {27'd0, o_wr_addr}, 32'd11);
        for (int i = 1; i <= 12; i++) step(1, 1, 0, 1, 0, 8'(8'h20 + i));
        check("f2_disp", {31'd0, o_disp_bank}, 32'd1);
        check("f2_cnt", {16'd0, o_frame_cnt}, 32'd2);
        check("f2_addr", {27'd0, o_wr_addr}, 32'd23);
        step(1, 1, 0, 1, 0, 8'h41);
        check("f3_addr0", {27'd0, o_wr_addr}, 32'd0);
        step(1, 1, 0, 1, 0, 8'h42);
        step(1, 1, 0, 1, 0, 8'h43);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 8'h44);
            check("stall_wr", {31'd0, o_wr_en}, 32'd0);
        end
        for (int i = 4; i <= 12; i++) step(1, 1, 0, 1, 0, 8'(8'h40 + i));
        for (int i = 1; i <= 5; i++) step(1, 1, 0, 1, 0, 8'(8'h50 + i));
        step(1, 1, 1, 1, 0, 8'hAA);
        check("sof_err", {31'd0, o_frame_err}, 32'd1);
        check("sof_addr", {27'd0, o_wr_addr}, 32'd12);
        check("sof_data", {24'd0, o_wr_data}, 32'hAA);
        check("sof_cnt", {16'd0, o_frame_cnt}, 32'd3);
        for (int i = 2; i <= 12; i++) step(1, 1, 0, 1, 0, 8'(8'h60 + i));
        for (int i = 1; i <= 6; i++) step(1, 1, 0, 1, 0, 8'(8'h70 + i));
        for (int i = 7; i <= 12; i++) step(1, 0, 0, 1, 0, 8'(8'h70 + i));
        check("drop_done", {31'd0, o_frame_done}, 32'd1);
        step(1, 0, 0, 1, 0, 8'h99);
        check("idle_ready", {31'd0, o_data_ready}, 32'd0);
        check("idle_wr", {31'd0, o_wr_en}, 32'd0);
        step(1, 1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 3; i++) step(1, 1, 0, 1, 0, 8'(8'h80 + i));
        step(0, 1, 0, 1, 0, 8'h84);
        check("rst_wr", {31'd0, o_wr_en}, 32'd0);
        check("rst_disp", {31'd0, o_disp_bank}, 32'd0);
        check("rst_cnt2", {16'd0, o_frame_cnt}, 32'd0);
        step(1, 1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'h91);
        check("reen_addr", {27'd0, o_wr_addr}, 32'd0);
        check("reen_wr", {31'd0, o_wr_en}, 32'd1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vp_frame_writer.md
Name: vp_frame_writer

Overview:
- Downstream neighbour of the video-processing stage.
- Consumes the 8-bit Sobel/threshold pixel stream over a ready/valid handshake.
- Converts the stream into raster write addresses for a double-buffered frame memory (BRAM write port).
- Flips banks on each completed frame so the display side always reads a whole, stable frame.

Parameters:
- DW, 8: pixel width.
- COLS, 640: pixels per line.
- ROWS, 480: lines per frame.
- AW, 20: write-address width; must satisfy 2^AW >= 2*COLS*ROWS.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_enable  in  1  level; allows frame capture to start/continue
- i_sof  in  1  start-of-frame resync pulse
- i_data_valid  in  1  upstream pixel valid
- o_data_ready  out  1  ready to accept pixel
- i_data  in  DW  pixel
- i_wr_stall  in  1  memory cannot take a write this cycle
- o_wr_en  out  1  memory write strobe
- o_wr_addr  out  AW  memory write address
- o_wr_data  out  DW  memory write data
- o_disp_bank  out  1  bank holding the last completed frame
- o_frame_done  out  1  one-cycle pulse, frame completed
- o_frame_err  out  1  one-cycle pulse, frame aborted by i_sof
- o_frame_cnt  out  16  completed-frame count, wraps at 0xFFFF->0

Behaviour:
- Reset is synchronous and active-low on i_rstn; the clock is i_clk.
- Reset values:
  - All outputs 0.
  - State IDLE; col/row counters 0; write bank 0; o_disp_bank 0.
- State machine:
  - IDLE -> RUN when i_enable=1; counters are already 0.
  - RUN -> IDLE only at frame completion with i_enable=0.
  - Dropping i_enable mid-frame does not stop capture; the current frame finishes first.
- Handshake:
  - o_data_ready = (state==RUN) && !i_wr_stall. This is combinational, so no pixel is accepted while the memory is stalled.
  - A transfer occurs on a cycle with i_data_valid && o_data_ready; i_data is sampled that edge.
  - Valid may be held indefinitely; no transfer occurs without ready.
- Write port, latency 1:
  - The cycle after a transfer: o_wr_en=1, o_wr_data=the sampled pixel.
  - o_wr_addr = wbank*COLS*ROWS + row*COLS + col, using counter values at transfer time.
  - Otherwise o_wr_en=0; addr/data hold their last values.
- Counters:
  - col increments per transfer.
  - At col==COLS-1: col->0, row increments.
  - At row==ROWS-1 && col==COLS-1 (last pixel): counters->0, and the next cycle carries:
    - o_wr_en for the last pixel;
    - o_frame_done=1;
    - o_disp_bank <= old wbank; wbank toggles;
    - o_frame_cnt increments.
  - The first pixel of the next frame can be accepted the cycle right after the last pixel, with no bubble.
  - Address arithmetic uses AW-bit unsigned values; no overflow is permitted by the parameter constraint.
- i_sof in RUN:
  - If counters are non-zero: counters reset to 0, wbank unchanged, o_frame_err pulses the next cycle, o_frame_done not asserted, o_disp_bank unchanged.
  - If counters are already 0: no error pulse.
  - i_sof coincident with a transfer: sof takes priority for counter reset. The pixel is written at offset 0 of the current bank, and counters become (row 0, col 1).
- i_sof in IDLE is ignored.
- i_rstn low mid-frame:
  - Next edge returns every output and counter to its reset value.
  - Any pending write is discarded (o_wr_en=0).

Test Plan (COLS=4, ROWS=3, AW=5):
- Reset then i_enable=1; stream 12 pixels 0x01..0x0C, valid=1 continuously -> writes addr 0..11 with data 0x01..0x0C, each 1 cycle after accept. o_frame_done pulses with the 12th write; o_disp_bank=0; o_frame_cnt=1.
- Continue streaming a second frame 0x21..0x2C -> addresses 12..23, no bubble between frames. o_disp_bank=1 after done; o_frame_cnt=2. A third frame returns to addr 0.
- Hold i_wr_stall=1 for 3 cycles mid-line while valid=1 -> o_data_ready=0 and no writes during the stall. The pixel is written once after the stall, with the address sequence unbroken.
- After 5 pixels of a frame, pulse i_sof together with a valid pixel 0xAA -> o_frame_err pulses, 0xAA is written at addr 0 of the same bank, the next pixel goes to addr 1, and o_frame_cnt is unchanged.
- Drop i_enable after pixel 6 of a frame -> the remaining 6 pixels are still accepted and frame_done pulses. After that the FSM is in IDLE: o_data_ready=0 and an offered valid pixel gets no write.
- Assert i_rstn=0 for 1 cycle mid-frame with a write pending -> o_wr_en=0, o_disp_bank=0, o_frame_cnt=0. After re-enable, the first pixel is written to addr 0.
